regfile_wb_arbiter: RTL

//  Write-side master of the 32x32 register file: owns the single write port (RegWrite/rd/write_data).

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/wb_result_fifo.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file write-side arbiter.
package regfile_wb_arbiter_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_SIZE = 32;
   localparam int unsigned REG_AW   = $clog2(REG_SIZE);

   typedef enum logic [1:0] {WB_SRC_NONE, WB_SRC_PIPE, WB_SRC_LL} wb_src_e;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO buffering long-latency write-back results; pointers carry one extra wrap bit.
module wb_result_fifo
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  logic    pop,
   input  wb_req_t din,
   output wb_req_t dout,
   output logic    full,
   output logic    empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   wb_req_t     mem [DEPTH];

   logic do_push;
   logic do_pop;

   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      do_push = push && !full;
      do_pop  = pop && !empty;
      dout    = mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs buffered LL results, LL scoreboard, starvation hold.
// Optional build macro LL_BYPASS_EN lets an LL result skip an empty FIFO.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              ll_valid,
   output logic              ll_ready,
   input  logic [REG_AW-1:0] ll_rd,
   input  logic [XLEN-1:0]   ll_data,
   input  logic              issue_valid,
   input  logic [REG_AW-1:0] issue_rd,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              wb_hold,
   output logic              RegWrite,
   output logic [REG_AW-1:0] rd,
   output logic [XLEN-1:0]   write_data
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic                pipe_win;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;
   logic                fifo_pop;
   logic                ll_fire;
   logic                bypass_ok;
   logic                bypass;
   logic                ll_retire;
   wb_req_t             ll_req;
   wb_req_t             fifo_head;
   wb_src_e             out_src;
   logic [REG_SIZE-1:0] busy;
   logic [SW-1:0]       starve_cnt;

   // Port selection and LL handshake.
   always_comb begin
      pipe_win  = wb_valid && (wb_rd != '0);
      fifo_pop  = !pipe_win && !fifo_empty;
`ifdef LL_BYPASS_EN
      bypass_ok = !pipe_win && fifo_empty;
`else
      bypass_ok = 1'b0;
`endif
      ll_ready  = !rst && (!fifo_full || bypass_ok);
      ll_fire   = ll_valid && ll_ready;
      bypass    = ll_fire && bypass_ok;
      fifo_push = ll_fire && !bypass && (ll_rd != '0);
      ll_req    = '{rd: ll_rd, data: ll_data};
      ll_retire = RegWrite && (out_src == WB_SRC_LL);
      rs1_busy  = busy[rs1] && !(ll_retire && (rd == rs1));
      rs2_busy  = busy[rs2] && !(ll_retire && (rd == rs2));
      wb_hold   = !rst && (starve_cnt >= SW'(STARVE_LIMIT));
   end

   wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (ll_req),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Registered write port; rd/write_data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWrite   <= 1'b0;
         rd         <= '0;
         write_data <= '0;
         out_src    <= WB_SRC_NONE;
      end else if (pipe_win) begin
         RegWrite   <= 1'b1;
         rd         <= wb_rd;
         write_data <= wb_data;
         out_src    <= WB_SRC_PIPE;
      end else if (fifo_pop) begin
         RegWrite   <= 1'b1;
         rd         <= fifo_head.rd;
         write_data <= fifo_head.data;
         out_src    <= WB_SRC_LL;
      end else if (bypass && (ll_rd != '0)) begin
         RegWrite   <= 1'b1;
         rd         <= ll_rd;
         write_data <= ll_data;
         out_src    <= WB_SRC_LL;
      end else begin
         RegWrite   <= 1'b0;
         out_src    <= WB_SRC_NONE;
      end
   end

   // Scoreboard: a same-cycle issue overrides the retire clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (ll_retire) busy[rd] <= 1'b0;
         if (issue_valid && (issue_rd != '0)) busy[issue_rd] <= 1'b1;
         busy[0] <= 1'b0;
      end
   end

   // Counts cycles the FIFO head is blocked by the pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (fifo_empty || fifo_pop) begin
         starve_cnt <= '0;
      end else if (pipe_win && (starve_cnt < SW'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   // A pipeline write to a register still owed by an LL op is an ID-stage bug.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(pipe_win && busy[wb_rd] && !(ll_retire && (rd == wb_rd))))
            else $error("WAW: pipeline write to busy x%0d", wb_rd);
      end
   end

endmodule
